lfsr_tick_stepper: RTL and testbench

- Consumes the divided slow clock produced by the clock divider stage. Advances a Fibonacci LFSR by one step per slow-clock rising edge.
- All logic runs on the fast system clock. The slow clock is treated as an asynchronous level and synchronised, never used as a clock.
- Provides start/stop/single-step control, seed loading, step counting and period-completion detection for the display/output stage downstream.

---
 rtl/lfsr_tick_stepper.sv | 119 +++++++++++
 tb/tb_lfsr_tick_stepper.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/lfsr_tick_stepper.sv
// Fibonacci LFSR advanced once per synchronised slow_clk rising edge (RUN) or per step_req (HALT),
// with seed loading, step counting and period-completion detection.
module lfsr_tick_stepper #(
    parameter int unsigned      WIDTH = 8,
    parameter logic [WIDTH-1:0] TAPS  = WIDTH'(8'hB8),
    parameter logic [WIDTH-1:0] SEED  = WIDTH'(8'h01)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             slow_clk,
    input  logic             start,
    input  logic             stop,
    input  logic             step_req,
    input  logic             load,
    input  logic [WIDTH-1:0] seed_in,
    output logic [WIDTH-1:0] lfsr_q,
    output logic [31:0]      step_count,
    output logic [31:0]      period_len,
    output logic             period_done,
    output logic             running,
    output logic             seed_err
);

    localparam int unsigned CNT_W = 32;

    typedef enum logic {
        HALT = 1'b0,
        RUN  = 1'b1
    } state_e;

    state_e             state_q, state_d;
    logic               s1_q, s2_q, s3_q;
    logic [WIDTH-1:0]   lfsr_d;
    logic [WIDTH-1:0]   seed_q, seed_d;
    logic [CNT_W-1:0]   step_count_q, step_count_d;
    logic [CNT_W-1:0]   period_len_q, period_len_d;
    logic               period_done_q, period_done_d;
    logic               seed_err_q, seed_err_d;
    logic               tick_c;
    logic               step_c;
    logic [WIDTH-1:0]   next_c;

    // One-clk pulse per synchronised slow_clk rising edge
    assign tick_c = s2_q & ~s3_q;
    assign step_c = (state_q == RUN) ? (tick_c & ~stop) : step_req;
    assign next_c = {lfsr_q[WIDTH-2:0], ^(lfsr_q & TAPS)};

    always_comb begin
        state_d       = state_q;
        lfsr_d        = lfsr_q;
        seed_d        = seed_q;
        step_count_d  = step_count_q;
        period_len_d  = period_len_q;
        period_done_d = 1'b0;
        seed_err_d    = seed_err_q;

        if (state_q == HALT) begin
            if (start) state_d = RUN;
        end else begin
            if (stop) state_d = HALT;
        end

        // Load wins over step; a zero seed would lock the LFSR so SEED is substituted
        if (load) begin
            step_count_d = '0;
            if (seed_in == '0) begin
                lfsr_d     = SEED;
                seed_d     = SEED;
                seed_err_d = 1'b1;
            end else begin
                lfsr_d     = seed_in;
                seed_d     = seed_in;
                seed_err_d = 1'b0;
            end
        end else if (step_c) begin
            lfsr_d = next_c;
            if (next_c == seed_q) begin
                period_done_d = 1'b1;
                period_len_d  = step_count_q + CNT_W'(1);
                step_count_d  = '0;
            end else begin
                step_count_d  = step_count_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= HALT;
            s1_q          <= 1'b0;
            s2_q          <= 1'b0;
            s3_q          <= 1'b0;
            lfsr_q        <= SEED;
            seed_q        <= SEED;
            step_count_q  <= '0;
            period_len_q  <= '0;
            period_done_q <= 1'b0;
            seed_err_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            s1_q          <= slow_clk;
            s2_q          <= s1_q;
            s3_q          <= s2_q;
            lfsr_q        <= lfsr_d;
            seed_q        <= seed_d;
            step_count_q  <= step_count_d;
            period_len_q  <= period_len_d;
            period_done_q <= period_done_d;
            seed_err_q    <= seed_err_d;
        end
    end

    assign step_count  = step_count_q;
    assign period_len  = period_len_q;
    assign period_done = period_done_q;
    assign running     = (state_q == RUN);
    assign seed_err    = seed_err_q;

endmodule

// File: tb/tb_lfsr_tick_stepper.sv
// Directed scoreboard bench for lfsr_tick_stepper: expectations are queued at stimulus time
// and popped when the corresponding DUT output is sampled.
module tb_lfsr_tick_stepper;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        slow_clk;
    logic        start;
    logic        stop;
    logic        step_req;
    logic        load;
    logic [7:0]  seed_in;
    logic [7:0]  lfsr_q;
    logic [31:0] step_count;
    logic [31:0] period_len;
    logic        period_done;
    logic        running;
    logic        seed_err;

    lfsr_tick_stepper dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .slow_clk    (slow_clk),
        .start       (start),
        .stop        (stop),
        .step_req    (step_req),
        .load        (load),
        .seed_in     (seed_in),
        .lfsr_q      (lfsr_q),
        .step_count  (step_count),
        .period_len  (period_len),
        .period_done (period_done),
        .running     (running),
        .seed_err    (seed_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    int          pulses = 0;
    int          pulse_step = 0;
    int          cur_step = 0;
    int          repeats = 0;
    bit          seen [256];
    logic [7:0]  model;

    // Independent model of the x^8+x^6+x^5+x^4+1 shift-left Fibonacci LFSR
    function automatic logic [7:0] lfsr_next(input logic [7:0] v);
        logic fb;
        fb = v[7] ^ v[5] ^ v[4] ^ v[3];
        return {v[6:0], fb};
    endfunction

    task automatic push(input string tag, input logic [31:0] val);
        exp_t e;
        e.tag = tag;
        e.val = val;
        sb.push_back(e);
    endtask

    task automatic pop_check(input logic [31:0] obs);
        exp_t e;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $error("FAIL scoreboard_empty observed=%0h", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.val) else begin
                errors++;
                $error("FAIL %s observed=%0h expected=%0h", e.tag, obs, e.val);
            end
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
        if (period_done === 1'b1) begin
            pulses++;
            pulse_step = cur_step;
        end
    endtask

    // One slow_clk period at divider scale 4; the step lands on the 3rd edge
    task automatic rise_step();
        slow_clk = 1'b1;
        cyc();
        cyc();
        slow_clk = 1'b0;
        cyc();
        cyc();
    endtask

    task automatic pulse_load(input logic [7:0] v);
        load    = 1'b1;
        seed_in = v;
        cyc();
        load    = 1'b0;
    endtask

    initial begin
        rst_n    = 1'b0;
        slow_clk = 1'b0;
        start    = 1'b0;
        stop     = 1'b0;
        step_req = 1'b0;
        load     = 1'b0;
        seed_in  = 8'h00;
        #23;

        push("rst_lfsr", 32'h01);        pop_check(32'(lfsr_q));
        push("rst_step_count", 32'h0);   pop_check(step_count);
        push("rst_period_len", 32'h0);   pop_check(period_len);
        push("rst_period_done", 32'h0);  pop_check(32'(period_done));
        push("rst_running", 32'h0);      pop_check(32'(running));
        push("rst_seed_err", 32'h0);     pop_check(32'(seed_err));

        rst_n = 1'b1;
        cyc();
        cyc();

        // Load 0x01, start, one slow_clk rise
        pulse_load(8'h01);
        start = 1'b1;
        cyc();
        start = 1'b0;
        model = 8'h01;
        seen[model] = 1'b1;
        slow_clk = 1'b1;
        cyc();
        cyc();
        push("first_step_not_early", 32'h01);
        pop_check(32'(lfsr_q));
        cyc();
        model = lfsr_next(model);
        cur_step = 1;
        push("first_step_lfsr", 32'(model));
        pop_check(32'(lfsr_q));
        slow_clk = 1'b0;
        cyc();
        push("first_step_count", 32'd1); pop_check(step_count);
        push("first_running", 32'd1);    pop_check(32'(running));
        seen[model] = 1'b1;

        // Remaining 254 steps of the full period
        for (int i = 2; i <= 255; i++) begin
            cur_step = i;
            model = lfsr_next(model);
            push("period_lfsr", 32'(model));
            rise_step();
            pop_check(32'(lfsr_q));
            if (i < 255) begin
                if (seen[lfsr_q]) repeats++;
                seen[lfsr_q] = 1'b1;
            end
        end
        push("period_pulses", 32'd1);      pop_check(32'(pulses));
        push("period_pulse_step", 32'd255); pop_check(32'(pulse_step));
        push("period_no_repeat", 32'd0);   pop_check(32'(repeats));
        push("period_lfsr_seed", 32'h01);  pop_check(32'(lfsr_q));
        push("period_len", 32'd255);       pop_check(period_len);
        push("period_step_count", 32'd0);  pop_check(step_count);

        // HALT: slow_clk ignored, step_req steps
        stop = 1'b1;
        cyc();
        stop = 1'b0;
        push("halt_running", 32'd0);       pop_check(32'(running));
        rise_step();
        rise_step();
        push("halt_tick_ignored", 32'h01); pop_check(32'(lfsr_q));
        for (int i = 0; i < 3; i++) begin
            step_req = 1'b1;
            slow_clk = ~slow_clk;
            cyc();
            step_req = 1'b0;
            slow_clk = ~slow_clk;
            cyc();
        end
        push("halt_step_lfsr", 32'h08);    pop_check(32'(lfsr_q));
        push("halt_step_count", 32'd3);    pop_check(step_count);

        // Zero seed substitution, then a legal seed
        pulse_load(8'h00);
        push("zero_load_lfsr", 32'h01);    pop_check(32'(lfsr_q));
        push("zero_load_err", 32'd1);      pop_check(32'(seed_err));
        push("zero_load_count", 32'd0);    pop_check(step_count);
        pulse_load(8'hA5);
        push("a5_load_lfsr", 32'hA5);      pop_check(32'(lfsr_q));
        push("a5_load_err", 32'd0);        pop_check(32'(seed_err));

        // RUN: load coincident with tick drops the step
        start = 1'b1;
        cyc();
        start = 1'b0;
        push("run_again", 32'd1);          pop_check(32'(running));
        slow_clk = 1'b1;
        cyc();
        cyc();
        pulse_load(8'h3C);
        slow_clk = 1'b0;
        cyc();
        cyc();
        push("load_tick_lfsr", 32'h3C);    pop_check(32'(lfsr_q));
        push("load_tick_count", 32'd0);    pop_check(step_count);

        // Stop coincident with tick: no step
        slow_clk = 1'b1;
        cyc();
        cyc();
        stop = 1'b1;
        cyc();
        stop = 1'b0;
        slow_clk = 1'b0;
        cyc();
        cyc();
        push("stop_tick_lfsr", 32'h3C);    pop_check(32'(lfsr_q));
        push("stop_tick_running", 32'd0);  pop_check(32'(running));
        push("stop_tick_count", 32'd0);    pop_check(step_count);

        // RUN one step from 0x3C, then asynchronous reset mid-cycle
        start = 1'b1;
        cyc();
        start = 1'b0;
        push("pre_reset_lfsr", 32'(lfsr_next(8'h3C)));
        rise_step();
        pop_check(32'(lfsr_q));
        slow_clk = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        push("async_rst_lfsr", 32'h01);    pop_check(32'(lfsr_q));
        push("async_rst_running", 32'd0);  pop_check(32'(running));
        push("async_rst_count", 32'd0);    pop_check(step_count);
        #2;
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) cyc();
        push("post_rst_tick_ignored", 32'h01); pop_check(32'(lfsr_q));
        push("post_rst_count", 32'd0);     pop_check(step_count);

        if (sb.size() != 0) begin
            checks++;
            errors++;
            $error("FAIL scoreboard_leftover observed=%0d expected=0", sb.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
